// File: rtl/ram8_scan.sv
// ram8_scan: 8 x 16-bit register bank with a random-access Hack-style port and a
// sequential scan engine. Optional macro RAM8_FWD_EN enables write-first forwarding on out.
`timescale 1ns/1ps
module ram8_scan (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  output logic [15:0] out,
  input  logic        scan_start,
  output logic        scan_busy,
  output logic        scan_valid,
  output logic [2:0]  scan_idx,
  output logic [15:0] scan_data,
  output logic        scan_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  logic [15:0] word_q [8];
  logic [15:0] rd_mux;
  state_e      state_q;
  logic [2:0]  ptr_q;
  logic [2:0]  ptr_d;
  logic        scan_valid_q;
  logic        scan_done_q;
  logic [2:0]  scan_idx_q;
  logic [15:0] scan_data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) word_q[i] <= '0;
    end else if (load) begin
      word_q[address] <= in;
    end
  end

  // Read select ordered exactly like a Mux8Way16 with sel=address
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: rd_mux = word_q[0];
      3'd1: rd_mux = word_q[1];
      3'd2: rd_mux = word_q[2];
      3'd3: rd_mux = word_q[3];
      3'd4: rd_mux = word_q[4];
      3'd5: rd_mux = word_q[5];
      3'd6: rd_mux = word_q[6];
      3'd7: rd_mux = word_q[7];
      default: rd_mux = '0;
    endcase
  end

`ifdef RAM8_FWD_EN
  assign out = load ? in : rd_mux;
`else
  assign out = rd_mux;
`endif

  assign ptr_d = ptr_q + 3'd1;

  // Scan samples pre-edge storage, so a same-edge write is seen only on the next scan
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      scan_valid_q <= 1'b0;
      scan_done_q  <= 1'b0;
      scan_idx_q   <= '0;
      scan_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (scan_start) begin
            state_q <= S_RUN;
            ptr_q   <= '0;
          end
        end
        S_RUN: begin
          scan_data_q  <= word_q[ptr_q];
          scan_idx_q   <= ptr_q;
          scan_valid_q <= 1'b1;
          ptr_q        <= ptr_d;
          if (ptr_q == 3'd7) begin
            scan_done_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          scan_valid_q <= 1'b0;
          scan_done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign scan_busy  = (state_q != S_IDLE);
  assign scan_valid = scan_valid_q;
  assign scan_done  = scan_done_q;
  assign scan_idx   = scan_idx_q;
  assign scan_data  = scan_data_q;

endmodule

// File: tb/tb_ram8_scan.sv
// Scoreboard bench for ram8_scan: driver updates an edge-counting reference model and
// queues expected scan beats; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ram8_scan;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic [2:0]  address = '0;
  logic [15:0] out;
  logic        scan_start = 1'b0;
  logic        scan_busy;
  logic        scan_valid;
  logic [2:0]  scan_idx;
  logic [15:0] scan_data;
  logic        scan_done;

  ram8_scan dut (
    .clock(clock), .reset_n(reset_n), .in(in), .load(load), .address(address),
    .out(out), .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_idx(scan_idx), .scan_data(scan_data), .scan_done(scan_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
    logic        done;
  } beat_t;

  beat_t       sb [$];
  logic [15:0] mem [8];
  int          ecount = 0;
  int          acc_edge = 0;
  bit          has_acc = 0;
  bit          valid_exp = 0;
  bit          busy_exp = 0;
  bit          mon_en = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // Model: a scan accepted at edge A emits beat k at edge A+k+1 from pre-edge storage;
  // the engine is idle again for start sampling from edge A+10.
  task automatic step(input logic ld, input logic [2:0] a, input logic [15:0] d, input logic st);
    int    dd;
    bit    idle;
    beat_t b;
    load = ld; address = a; in = d; scan_start = st;
    @(posedge clock);
    ecount++;
    idle = 1'b1;
    if (has_acc) begin
      dd = ecount - acc_edge;
      if (dd >= 1 && dd <= 8) begin
        b.idx  = 3'(dd - 1);
        b.data = mem[dd - 1];
        b.done = (dd == 8);
        sb.push_back(b);
      end
      idle = (dd >= 10);
    end
    if (idle && st) begin
      acc_edge = ecount;
      has_acc  = 1'b1;
    end
    if (ld) mem[a] = d;
    dd = has_acc ? (ecount - acc_edge) : 1000;
    valid_exp = (dd >= 1 && dd <= 8);
    busy_exp  = (dd <= 8);
    #1;
  endtask

  task automatic do_reset();
    load = 1'b0; scan_start = 1'b0; in = '0; address = '0;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(scan_valid), 32'd0);
    chk("rst_busy",  32'(scan_busy),  32'd0);
    chk("rst_done",  32'(scan_done),  32'd0);
    chk("rst_idx",   32'(scan_idx),   32'd0);
    chk("rst_data",  32'(scan_data),  32'd0);
    chk("rst_out",   32'(out),        32'd0);
    for (int i = 0; i < 8; i++) mem[i] = '0;
    has_acc = 0; valid_exp = 0; busy_exp = 0;
    sb.delete();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 16'h0, 1'b0);
  endtask

  always @(negedge clock) begin
    logic [15:0] exp_out;
    beat_t       b;
    if (reset_n && mon_en) begin
      exp_out = mem[address];
`ifdef RAM8_FWD_EN
      if (load) exp_out = in;
`endif
      chk("out", 32'(out), 32'(exp_out));
      chk("scan_busy", 32'(scan_busy), 32'(busy_exp));
      chk("scan_valid", 32'(scan_valid), 32'(valid_exp));
      if (scan_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected at %0t: actual idx=%0d data=%h expected no beat",
                   $time, scan_idx, scan_data);
        end else begin
          b = sb.pop_front();
          chk("beat_idx",  32'(scan_idx),  32'(b.idx));
          chk("beat_data", 32'(scan_data), 32'(b.data));
          chk("beat_done", 32'(scan_done), 32'(b.done));
        end
      end else begin
        chk("done_idle", 32'(scan_done), 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fexp;
    #1;
    do_reset();
    mon_en = 1'b1;

    for (int k = 0; k < 8; k++) step(1'b0, 3'(k), 16'h0, 1'b0);

    for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 16'(k), 1'b0);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 5; j++) step(1'b0, 3'(k), 16'h0, 1'b0);

    for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 16'h1000 + 16'(k), 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1);
    idle_steps(12);

    // Write to word 3 on the edge that samples idx 3, then rescan
    step(1'b0, 3'd0, 16'h0, 1'b1);
    idle_steps(3);
    step(1'b1, 3'd3, 16'hBEEF, 1'b0);
    idle_steps(8);
    step(1'b0, 3'd0, 16'h0, 1'b1);
    idle_steps(12);

    // Held start: restarts on the first idle edge
    for (int i = 0; i < 24; i++) step(1'b0, 3'(i), 16'h0, 1'b1);
    idle_steps(12);

    // Abort after the idx-4 beat has been seen
    step(1'b0, 3'd0, 16'h0, 1'b1);
    idle_steps(5);
    @(negedge clock);
    #1;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b0, 3'(k), 16'h0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1);
    idle_steps(12);

    load = 1'b1; address = 3'd5; in = 16'h5A5A; scan_start = 1'b0;
    #1;
`ifdef RAM8_FWD_EN
    fexp = 16'h5A5A;
`else
    fexp = mem[5];
`endif
    chk("fwd_out", 32'(out), 32'(fexp));
    step(1'b1, 3'd5, 16'h5A5A, 1'b0);
    step(1'b0, 3'd5, 16'h0, 1'b0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 7) == 0);
    idle_steps(12);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
